rgb_pwm: RTL and testbench

Three-channel PWM controller for the board's RGB LED, sitting between the arduFPGA core's 8-bit IO bus and the three open-drain LED pad buffers. The core writes per-channel duty, enable and prescale registers. The block produces three active-high `led[2:0]` levels that the top level inverts into the open-drain pads. Duty updates are double-buffered so that a period is never truncated or glitched.

---
 rtl/rgb_pwm_pkg.sv | 11 +
 rtl/rgb_pwm_if.sv | 11 +
 rtl/rgb_pwm_channel.sv | 45 ++++
 rtl/rgb_pwm.sv | 100 ++++++++++
 tb/tb_rgb_pwm.sv | 132 +++++++++++++
 5 files changed

// File: rtl/rgb_pwm_pkg.sv
// rgb_pwm_pkg: register offsets and widths shared by the rgb_pwm block.
package rgb_pwm_pkg;
  localparam int NUM_CH = 3;
  localparam int DUTY_W = 8;
  localparam logic [7:0] CTRL_OFS     = 8'd0;
  localparam logic [7:0] DUTY_R_OFS   = 8'd1;
  localparam logic [7:0] DUTY_G_OFS   = 8'd2;
  localparam logic [7:0] DUTY_B_OFS   = 8'd3;
  localparam logic [7:0] PRESCALE_OFS = 8'd4;
  localparam logic [7:0] STATUS_OFS   = 8'd5;
endpackage

// File: rtl/rgb_pwm_if.sv
// rgb_pwm_if: 8-bit IO bus (core is master, rgb_pwm is slave).
// io_addr/io_out/io_write/io_read from the core, io_in registered read data back.
interface rgb_pwm_if;
  logic [7:0] io_addr;
  logic [7:0] io_out;
  logic       io_write;
  logic       io_read;
  logic [7:0] io_in;
  modport master (output io_addr, io_out, io_write, io_read, input io_in);
  modport slave  (input io_addr, io_out, io_write, io_read, output io_in);
endinterface

// File: rtl/rgb_pwm_channel.sv
// rgb_pwm_channel: one PWM channel; shadow/active duty, compare, registered led.
// Ports: phase/wrap from the shared counter, en, we/wdata duty write, shadow readback, led.
// With RGB_PWM_BREATHE_EN the compared duty is scaled by the envelope (env, breathe).
module rgb_pwm_channel
  import rgb_pwm_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        phase,
  input  logic              wrap,
  input  logic              en,
  input  logic              we,
  input  logic [DUTY_W-1:0] wdata,
`ifdef RGB_PWM_BREATHE_EN
  input  logic [7:0]        env,
  input  logic              breathe,
`endif
  output logic [DUTY_W-1:0] shadow,
  output logic              led
);
  logic [DUTY_W-1:0] shadow_q, shadow_d, active_q, active_d, duty;
  logic              led_q, led_d;
  always_comb begin
    shadow_d = we ? wdata : shadow_q;
    active_d = wrap ? shadow_q : active_q;
`ifdef RGB_PWM_BREATHE_EN
    duty     = breathe ? DUTY_W'((16'(active_q) * (16'(env) + 16'd1)) >> 8) : active_q;
`else
    duty     = active_q;
`endif
    led_d    = en & (phase < duty);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      shadow_q <= '0;
      active_q <= '0;
      led_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      led_q    <= led_d;
    end
  assign shadow = shadow_q;
  assign led    = led_q;
endmodule

// File: rtl/rgb_pwm.sv
// rgb_pwm: three-channel RGB LED PWM with double-buffered duty registers.
// Ports: clk_i, rst_ni (async active-low), bus (rgb_pwm_if.slave), led[2:0] (1 = lit).
// Optional feature macro: RGB_PWM_BREATHE_EN (triangle envelope scaling via CTRL[3]).
module rgb_pwm
  import rgb_pwm_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR    = 8'h40,
  parameter logic [7:0] PRESCALE_RST = 8'd0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  rgb_pwm_if.slave          bus,
  output logic [NUM_CH-1:0] led
);
  logic [7:0]        ofs, rdata, ctrl_rd;
  logic              hit, wr, rd, tick, wrap;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [7:0]        prescale_q, prescale_d, pcnt_q, pcnt_d, phase_q, phase_d, io_in_q, io_in_d;
  logic              flag_q, flag_d;
  logic [DUTY_W-1:0] shadow [NUM_CH];
`ifdef RGB_PWM_BREATHE_EN
  logic              breathe_q, breathe_d, up_q, up_d;
  logic [7:0]        env_q, env_d;
  always_comb begin
    breathe_d = (wr && ofs == CTRL_OFS) ? bus.io_out[3] : breathe_q;
    env_d     = !breathe_q ? 8'd0 : !wrap ? env_q :
                up_q ? (env_q == 8'hff ? 8'hfe : env_q + 8'd1) :
                (env_q == 8'h00 ? 8'h01 : env_q - 8'd1);
    up_d      = !breathe_q ? 1'b1 : !wrap ? up_q : up_q ? (env_q != 8'hff) : (env_q == 8'h00);
    ctrl_rd   = {4'b0, breathe_q, en_q};
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      breathe_q <= 1'b0;
      up_q      <= 1'b1;
      env_q     <= '0;
    end else begin
      breathe_q <= breathe_d;
      up_q      <= up_d;
      env_q     <= env_d;
    end
`else
  assign ctrl_rd = {5'b0, en_q};
`endif
  always_comb begin
    // Offset arithmetic wraps mod 256, so a single compare decodes the 6-register window.
    ofs        = bus.io_addr - BASE_ADDR;
    hit        = ofs < 8'd6;
    wr         = bus.io_write & hit;
    rd         = bus.io_read & hit;
    // Equality (not >=) lets a counter above a newly written limit run on to 255 and wrap.
    tick       = pcnt_q == prescale_q;
    wrap       = tick & (phase_q == 8'hff);
    en_d       = (wr && ofs == CTRL_OFS) ? bus.io_out[NUM_CH-1:0] : en_q;
    prescale_d = (wr && ofs == PRESCALE_OFS) ? bus.io_out : prescale_q;
    pcnt_d     = tick ? 8'd0 : pcnt_q + 8'd1;
    phase_d    = phase_q + {7'd0, tick};
    flag_d     = wrap | (flag_q & ~(rd && ofs == STATUS_OFS));
    rdata      = ofs == CTRL_OFS     ? ctrl_rd :
                 ofs == DUTY_R_OFS   ? shadow[0] :
                 ofs == DUTY_G_OFS   ? shadow[1] :
                 ofs == DUTY_B_OFS   ? shadow[2] :
                 ofs == PRESCALE_OFS ? prescale_q : {4'b0, led, flag_q};
    io_in_d    = rd ? rdata : 8'd0;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      en_q       <= '0;
      prescale_q <= PRESCALE_RST;
      pcnt_q     <= '0;
      phase_q    <= '0;
      flag_q     <= 1'b0;
      io_in_q    <= '0;
    end else begin
      en_q       <= en_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      phase_q    <= phase_d;
      flag_q     <= flag_d;
      io_in_q    <= io_in_d;
    end
  assign bus.io_in = io_in_q;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rgb_pwm_channel u_ch (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .phase   (phase_q),
      .wrap    (wrap),
      .en      (en_q[i]),
      .we      (wr && ofs == DUTY_R_OFS + 8'(i)),
      .wdata   (bus.io_out),
`ifdef RGB_PWM_BREATHE_EN
      .env     (env_q),
      .breathe (breathe_q),
`endif
      .shadow  (shadow[i]),
      .led     (led[i])
    );
  end
endmodule

// File: tb/tb_rgb_pwm.sv
// tb_rgb_pwm: directed, table-driven bench for rgb_pwm (default build, breathe disabled).
module tb_rgb_pwm;
  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic [2:0] led;
  int         tests = 0, failed = 0, cyc = 0;
  rgb_pwm_if bus();
  rgb_pwm dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus), .led(led));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  typedef struct {
    string      name;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t vt[10];
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.io_addr = a; bus.io_out = d; bus.io_write = 1'b1;
    @(negedge clk);
    bus.io_write = 1'b0;
  endtask
  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.io_addr = a; bus.io_read = 1'b1;
    @(negedge clk);
    bus.io_read = 1'b0;
    d = bus.io_in;
  endtask
  task automatic wait_level(input int idx, input logic v, output int c);
    c = -1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (led[idx] == v) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check("wait_led_timeout", 0, 1);
  endtask
  task automatic count(input int idx, input int n_cyc, output int n);
    n = 0;
    repeat (n_cyc) begin
      @(negedge clk);
      n += int'(led[idx]);
    end
  endtask
  initial begin
    logic [7:0] d;
    int r, f, r2, f2, n, bad;
    vt[0] = '{"ctrl_ff",     8'h40, 8'hff, 8'h07};
    vt[1] = '{"ctrl_09",     8'h40, 8'h09, 8'h01};
    vt[2] = '{"duty_r",      8'h41, 8'h80, 8'h80};
    vt[3] = '{"duty_g",      8'h42, 8'h40, 8'h40};
    vt[4] = '{"duty_b",      8'h43, 8'hff, 8'hff};
    vt[5] = '{"prescale",    8'h44, 8'h03, 8'h03};
    vt[6] = '{"undecoded46", 8'h46, 8'h55, 8'h00};
    vt[7] = '{"undecoded3f", 8'h3f, 8'haa, 8'h00};
    vt[8] = '{"prescale0",   8'h44, 8'h00, 8'h00};
    vt[9] = '{"ctrl_00",     8'h40, 8'h00, 8'h00};
    bus.io_addr = 8'h00; bus.io_out = 8'h00; bus.io_write = 1'b0; bus.io_read = 1'b0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    bad = 0;
    repeat (600) begin
      @(negedge clk);
      if (led != 3'b000 || bus.io_in != 8'h00) bad++;
    end
    check("reset_idle_600", bad, 0);
    rd(8'h40, d); check("reset_ctrl", d, 0);
    rd(8'h41, d); check("reset_duty_r", d, 0);
    rd(8'h44, d); check("reset_prescale", d, 0);
    foreach (vt[i]) begin
      wr(vt[i].addr, vt[i].wdata);
      rd(vt[i].addr, d);
      check(vt[i].name, d, vt[i].exp);
    end
    wr(8'h41, 8'd0); wr(8'h43, 8'd0); wr(8'h42, 8'd64); wr(8'h40, 8'h02); wr(8'h44, 8'd0);
    repeat (600) @(negedge clk);
    count(1, 256, n); check("g_high_64", n, 64);
    count(0, 256, n); check("r_off", n, 0);
    count(2, 256, n); check("b_off", n, 0);
    wait_level(1, 1'b0, f); wait_level(1, 1'b1, r); wait_level(1, 1'b0, f);
    check("g_pulse_len", f - r, 64);
    wr(8'h41, 8'd128); wr(8'h40, 8'h01);
    repeat (600) @(negedge clk);
    wait_level(0, 1'b0, f); wait_level(0, 1'b1, r);
    repeat (8) @(negedge clk);
    wr(8'h41, 8'd32);
    rd(8'h41, d); check("shadow_readback", d, 32);
    wait_level(0, 1'b0, f); check("cur_period_128", f - r, 128);
    wait_level(0, 1'b1, r2); check("period_256", r2 - r, 256);
    wait_level(0, 1'b0, f2); check("next_period_32", f2 - r2, 32);
    wr(8'h40, 8'h04); wr(8'h43, 8'd0);
    repeat (600) @(negedge clk);
    count(2, 256, n); check("b_duty0", n, 0);
    wr(8'h43, 8'd255);
    repeat (600) @(negedge clk);
    count(2, 256, n); check("b_duty255", n, 255);
    wait_level(2, 1'b0, f); wait_level(2, 1'b1, r);
    check("b_low_one_step", r - f, 1);
    wr(8'h41, 8'd128); wr(8'h40, 8'h01); wr(8'h44, 8'd3);
    repeat (2100) @(negedge clk);
    wait_level(0, 1'b0, f); wait_level(0, 1'b1, r); wait_level(0, 1'b0, f);
    check("presc3_high_512", f - r, 512);
    wait_level(0, 1'b1, r2); check("presc3_period_1024", r2 - r, 1024);
    rd(8'h45, d); check("status_flag_set", int'(d[0]), 1);
    @(negedge clk); check("io_in_returns_0", bus.io_in, 0);
    rd(8'h45, d); check("status_flag_cleared", int'(d[0]), 0);
    repeat (1100) @(negedge clk);
    rd(8'h45, d); check("status_flag_reset_by_wrap", int'(d[0]), 1);
    wait_level(0, 1'b1, r);
    @(negedge clk);
    #2 rst_ni = 1'b0;
    #1 check("async_reset_led", led, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    rd(8'h40, d); check("post_rst_ctrl", d, 0);
    rd(8'h44, d); check("post_rst_prescale", d, 0);
    rd(8'h41, d); check("post_rst_duty_r", d, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
